// File: rtl/mux8_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_arb_pkg
//  Description : Shared widths and the arbiter state encoding for the
//                round-robin arbiter that drives an 8:1 one-bit mux.
//                  NREQ   - number of requesters
//                  SEL_W  - width of the mux select / pointer
//                  HOLD_W - width of the hold counter
//  Revision    : 1.0 - initial release
// ============================================================================
package mux8_arb_pkg;

    localparam int NREQ   = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick8
//  Description : Combinational round-robin pick. Finds the first set bit of
//                req scanning upward from start, wrapping 7 -> 0.
//  Ports       : req   [8] in  - request vector to search
//                start [3] in  - channel the search begins at
//                idx   [3] out - winning channel (valid when any = 1)
//                any       out - at least one request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [NREQ-1:0]  w_rot;
    logic [SEL_W-1:0] w_off;
    logic [SEL_W-1:0] w_src;

    // Rotate so that bit 0 of w_rot is channel 'start'; the index sum
    // wraps naturally in SEL_W bits.
    always_comb begin
        w_rot = '0;
        w_src = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_src    = SEL_W'(i) + start;
            w_rot[i] = req[w_src];
        end
    end

    // Lowest set bit of the rotated vector; scanning downward lets the
    // last assignment (the lowest index) win.
    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    // Un-rotate back to an absolute channel number.
    assign idx = start + w_off;
    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_rr_arbiter
//  Description : Round-robin arbiter in front of an 8:1 one-bit mux. Grants
//                are registered and one-hot; an owner keeps the grant while
//                it requests, for at most HOLD cycles when others wait.
//  Parameters  : HOLD - max consecutive grant cycles under contention (1..15)
//  Ports       : clk            in  - rising-edge clock
//                rst            in  - asynchronous active-high reset
//                req       [8]  in  - per-channel request
//                gnt       [8]  out - registered one-hot grant, 0 when idle
//                sel       [3]  out - mux select (granted channel)
//                sel_valid      out - gnt is non-zero
//                hold_cnt  [4]  out - cycles held by current owner, 0 idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              sel_valid,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam logic [HOLD_W-1:0] C_HOLD = HOLD_W'(HOLD);

    arb_state_t        state_q,     state_d;
    logic [NREQ-1:0]   gnt_q,       gnt_d;
    logic [SEL_W-1:0]  sel_q,       sel_d;
    logic              sel_valid_q, sel_valid_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;

    logic [NREQ-1:0]   w_others;
    logic [NREQ-1:0]   w_pick_req;
    logic [SEL_W-1:0]  w_idx;
    logic              w_any;
    logic              w_own;
    logic              w_at_hold;

    assign w_own     = req[sel_q];
    assign w_others  = req & ~(NREQ'(1) << sel_q);
    assign w_at_hold = (hold_cnt_q == C_HOLD);

    // While granting, ptr_q is always sel_q + 1, so searching the masked
    // vector from ptr_q is the "next winner after the owner" search. One
    // picker therefore serves both states.
    assign w_pick_req = (state_q == GRANT) ? w_others : req;

    rr_pick8 u_pick (
        .req   (w_pick_req),
        .start (ptr_q),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        hold_cnt_d  = hold_cnt_q;
        ptr_d       = ptr_q;

        unique case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d     = GRANT;
                    gnt_d       = NREQ'(1) << w_idx;
                    sel_d       = w_idx;
                    sel_valid_d = 1'b1;
                    hold_cnt_d  = HOLD_W'(1);
                    ptr_d       = w_idx + SEL_W'(1);
                end else begin
                    gnt_d       = '0;
                    sel_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                // Release and hold-expiry both hand over back-to-back when
                // someone else is waiting.
                if ((!w_own || w_at_hold) && w_any) begin
                    gnt_d       = NREQ'(1) << w_idx;
                    sel_d       = w_idx;
                    sel_valid_d = 1'b1;
                    hold_cnt_d  = HOLD_W'(1);
                    ptr_d       = w_idx + SEL_W'(1);
                end else if (!w_own) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    sel_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end else if (!w_at_hold) begin
                    hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
                end
                // Owner at HOLD with nobody waiting: keep grant, saturate.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            hold_cnt_q  <= hold_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign hold_cnt  = hold_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux8_rr_arbiter
//  Description : Directed self-checking bench for mux8_rr_arbiter (HOLD = 4)
//                with a behavioural 8:1 mux on sel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_valid;
    logic [3:0] hold_cnt;
    logic [7:0] x = 8'b1010_1010;
    logic       y;

    int n_checks = 0;
    int n_pass   = 0;

    mux8_rr_arbiter #(.HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .hold_cnt  (hold_cnt)
    );

    // Downstream 8:1 mux
    assign y = x[sel];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int es;

        // Reset state
        #3;
        check("rst_gnt",   32'(gnt),       32'h00);
        check("rst_sel",   32'(sel),       32'd0);
        check("rst_valid", 32'(sel_valid), 32'd0);
        check("rst_hold",  32'(hold_cnt),  32'd0);
        tick;
        rst = 1'b0;

        // Single request on channel 2: hold counts 1,2,3,4,4,4
        req = 8'h04;
        tick;
        check("single_gnt",   32'(gnt),       32'h04);
        check("single_sel",   32'(sel),       32'd2);
        check("single_valid", 32'(sel_valid), 32'd1);
        check("single_hold1", 32'(hold_cnt),  32'd1);
        for (int k = 2; k <= 6; k++) begin
            tick;
            check("single_hold", 32'(hold_cnt), (k > 4) ? 32'd4 : 32'(k));
            check("single_keep", 32'(gnt),      32'h04);
        end

        // Full contention from reset: 0x4, 1x4, ..., 7x4, 0x4
        rst = 1'b1;
        req = 8'hFF;
        #2;
        rst = 1'b0;
        for (int k = 0; k < 36; k++) begin
            tick;
            es = (k / 4) % 8;
            check("cont_sel",   32'(sel),       32'(es));
            check("cont_gnt",   32'(gnt),       32'd1 << es);
            check("cont_hold",  32'(hold_cnt),  32'((k % 4) + 1));
            check("cont_valid", 32'(sel_valid), 32'd1);
            check("cont_y",     32'(y),         32'(es % 2));
        end

        // Back-to-back release 7 -> 0
        rst = 1'b1;
        req = 8'h80;
        #2;
        rst = 1'b0;
        tick;
        check("b2b_sel7",  32'(sel),      32'd7);
        check("b2b_hold1", 32'(hold_cnt), 32'd1);
        req = 8'h81;
        tick;
        check("b2b_keep7", 32'(sel),      32'd7);
        check("b2b_hold2", 32'(hold_cnt), 32'd2);
        req = 8'h01;
        tick;
        check("b2b_sel0",  32'(sel),       32'd0);
        check("b2b_gnt0",  32'(gnt),       32'h01);
        check("b2b_hold",  32'(hold_cnt),  32'd1);
        check("b2b_valid", 32'(sel_valid), 32'd1);

        // Wrap-around: owner 6 at HOLD, req 0100_0010 -> winner 1, ptr 2
        rst = 1'b1;
        req = 8'h40;
        #2;
        rst = 1'b0;
        repeat (4) tick;
        check("wrap_sel6",  32'(sel),      32'd6);
        check("wrap_hold4", 32'(hold_cnt), 32'd4);
        req = 8'h42;
        tick;
        check("wrap_sel",  32'(sel),       32'd1);
        check("wrap_gnt",  32'(gnt),       32'h02);
        check("wrap_hold", 32'(hold_cnt),  32'd1);
        check("wrap_ptr",  32'(dut.ptr_q), 32'd2);

        // Release to idle: sel keeps its last value
        req = 8'h00;
        tick;
        check("idle_valid", 32'(sel_valid), 32'd0);
        check("idle_gnt",   32'(gnt),       32'h00);
        check("idle_hold",  32'(hold_cnt),  32'd0);
        check("idle_sel",   32'(sel),       32'd1);

        // Async reset mid-grant (ptr = 2 before, so channel 4 wins)
        req = 8'h30;
        tick;
        check("ar_sel_pre", 32'(sel), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("ar_gnt",   32'(gnt),       32'h00);
        check("ar_valid", 32'(sel_valid), 32'd0);
        check("ar_hold",  32'(hold_cnt),  32'd0);
        rst = 1'b0;
        tick;
        check("ar_sel_post", 32'(sel), 32'd4);
        check("ar_gnt_post", 32'(gnt), 32'h10);

        // Glitch between edges is ignored
        req = 8'h00;
        tick;
        check("gl_idle", 32'(sel_valid), 32'd0);
        #2;
        req = 8'hFF;
        #1;
        req = 8'h00;
        tick;
        check("gl_valid", 32'(sel_valid), 32'd0);
        check("gl_gnt",   32'(gnt),       32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
